// File: rtl/pipelined_bitwise_reduce_pkg.sv
// Shared definitions for the pipelined bitwise reduction tree:
// operation encodings and the identity element used to pad unused leaves.
package pipelined_bitwise_reduce_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND  = 2'b00;
    localparam op_t OP_OR   = 2'b01;
    localparam op_t OP_XOR  = 2'b10;
    localparam op_t OP_NAND = 2'b11;

    // Identity bit of each operation. NAND reduces as AND inside the tree,
    // so it shares AND's all-ones identity.
    function automatic logic identity_bit(input op_t op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One level of the reduction tree: folds pairs of W-bit lanes under the
// operation tag carried with the data, and registers the result together
// with its valid bit and tag.
module reduce_stage
    import pipelined_bitwise_reduce_pkg::*;
#(
    parameter int W     = 4,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 up_valid,
    input  op_t                  up_op,
    input  logic [2*LANES*W-1:0] up_data,
    output logic                 valid,
    output op_t                  op,
    output logic [LANES*W-1:0]   data
);

    logic [LANES*W-1:0] combined;

    // Pairwise combine of upstream lanes 2l and 2l+1 into output lane l.
    always_comb begin
        combined = '0;
        for (int l = 0; l < LANES; l++) begin
            case (up_op)
                OP_OR:   combined[l*W +: W] = up_data[2*l*W +: W] | up_data[(2*l+1)*W +: W];
                OP_XOR:  combined[l*W +: W] = up_data[2*l*W +: W] ^ up_data[(2*l+1)*W +: W];
                default: combined[l*W +: W] = up_data[2*l*W +: W] & up_data[(2*l+1)*W +: W];
            endcase
        end
    end

    // Stage register: takes the upstream slot whenever it may load; data and
    // tag only change when a real transaction arrives, so idle inputs are inert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            op    <= OP_AND;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                op   <= up_op;
                data <= combined;
            end
        end
    end

endmodule

// File: rtl/pipelined_bitwise_reduce.sv
// Streaming N-operand, W-bit bitwise reduction (AND/OR/XOR/NAND) built as a
// balanced binary tree with one register per level.
//
// Handshake: a word moves across an interface on every rising edge where
// valid && ready. in_valid must not depend on in_ready; in_ready may depend
// combinationally on out_ready so a full pipe keeps flowing as the consumer
// drains it.
module pipelined_bitwise_reduce
    import pipelined_bitwise_reduce_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         ASYNCRESETN,
    input  logic [N*W-1:0] I,
    input  logic [1:0]   OP,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] O,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int LEVELS = (N <= 1) ? 1 : $clog2(N);
    localparam int LEAVES = 1 << LEVELS;

    // leaves: padded operand lanes. nodes: outputs of every stage packed
    // back to back, level s starting at lane LEAVES - (LEAVES >> s).
    logic [LEAVES*W-1:0]     leaves;
    logic [(LEAVES-1)*W-1:0] nodes;
    logic [LEVELS-1:0]       stage_valid;
    op_t                     stage_op [LEVELS];
    logic [LEVELS-1:0]       load;
    logic                    ready_en;

    // Leaves beyond N carry the identity of the requested operation.
    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < N) begin : g_operand
            assign leaves[k*W +: W] = I[k*W +: W];
        end else begin : g_pad
            assign leaves[k*W +: W] = {W{identity_bit(OP)}};
        end
    end

    // in_ready is held low until the first edge after reset is released.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // A stage may load when it is empty or its content leaves this cycle;
    // the chain runs from the output back towards the input.
    always_comb begin
        logic carry;
        load  = '0;
        carry = out_ready;
        for (int s = LEVELS - 1; s >= 0; s--) begin
            carry   = !stage_valid[s] || carry;
            load[s] = carry;
        end
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_level
        localparam int OUT_LANES = LEAVES >> (s + 1);
        localparam int OUT_OFF   = LEAVES - (LEAVES >> s);

        logic [2*OUT_LANES*W-1:0] up_data;
        logic                     up_valid;
        op_t                      up_op;

        if (s == 0) begin : g_first
            assign up_data  = leaves;
            assign up_valid = in_valid && ready_en;
            assign up_op    = OP;
        end else begin : g_inner
            localparam int IN_OFF = LEAVES - (LEAVES >> (s - 1));
            assign up_data  = nodes[IN_OFF*W +: 2*OUT_LANES*W];
            assign up_valid = stage_valid[s-1];
            assign up_op    = stage_op[s-1];
        end

        reduce_stage #(
            .W     (W),
            .LANES (OUT_LANES)
        ) u_stage (
            .clk      (CLK),
            .rst_n    (ASYNCRESETN),
            .load     (load[s]),
            .up_valid (up_valid),
            .up_op    (up_op),
            .up_data  (up_data),
            .valid    (stage_valid[s]),
            .op       (stage_op[s]),
            .data     (nodes[OUT_OFF*W +: OUT_LANES*W])
        );
    end

    assign in_ready  = ready_en && load[0];
    assign out_valid = stage_valid[LEVELS-1];
    // NAND travels through the tree as AND and is inverted once here.
    assign O = nodes[(LEAVES-2)*W +: W] ^ {W{stage_op[LEVELS-1] == OP_NAND}};

endmodule
